// File: rtl/gate_edge_counter.sv
// Edge-count frequency meter: counts synchronised rising edges of sig_in_i between
// consecutive sample pulses, optionally averaging 2^WIN_LOG2 windows per result.
module gate_edge_counter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int WIN_LOG2    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_i,
  input  logic             enable_i,
  input  logic             sig_in_i,
  output logic [CNT_W-1:0] freq_count_o,
  output logic             freq_valid_o,
  output logic             overflow_o
);

  localparam int ACC_W = CNT_W + WIN_LOG2;
  localparam int IDX_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((64'd1 << WIN_LOG2) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic               win_sat_q, win_sat_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   sum_s;
  logic [ACC_W-1:0]   avg_s;
  logic [CNT_W-1:0]   start_cnt_s;

  // Synchroniser chain plus history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_s      = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign sum_s       = acc_q + ACC_W'(win_cnt_q);
  assign avg_s       = sum_s >> WIN_LOG2;
  // An edge coincident with the closing sample opens the next window.
  assign start_cnt_s = {{(CNT_W-1){1'b0}}, edge_s};

  // Window/accumulate FSM next-state and result logic
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    win_sat_d = win_sat_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    idx_d     = idx_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    if (!enable_i) begin
      state_d   = IDLE;
      win_cnt_d = '0;
      win_sat_d = 1'b0;
      acc_d     = '0;
      sat_d     = 1'b0;
      idx_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARM;
          win_cnt_d = '0;
          win_sat_d = 1'b0;
          acc_d     = '0;
          sat_d     = 1'b0;
          idx_d     = '0;
        end
        ARM: begin
          if (sample_i) begin
            state_d   = COUNT;
            win_cnt_d = start_cnt_s;
            win_sat_d = 1'b0;
          end else begin
            state_d = ARM;
          end
        end
        COUNT: begin
          if (sample_i) begin
            win_cnt_d = start_cnt_s;
            win_sat_d = 1'b0;
            if (idx_q == IDX_LAST) begin
              count_d = avg_s[CNT_W-1:0];
              ovf_d   = sat_q | win_sat_q;
              valid_d = 1'b1;
              acc_d   = '0;
              sat_d   = 1'b0;
              idx_d   = '0;
            end else begin
              acc_d = sum_s;
              sat_d = sat_q | win_sat_q;
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (edge_s) begin
            if (win_cnt_q == CNT_MAX) begin
              win_sat_d = 1'b1;
            end else begin
              win_cnt_d = win_cnt_q + CNT_W'(1);
            end
          end else begin
            win_cnt_d = win_cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM, counters and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      win_sat_q <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      idx_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      win_sat_q <= win_sat_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign freq_count_o = count_q;
  assign freq_valid_o = valid_q;
  assign overflow_o   = ovf_q;

endmodule
